// File: rtl/adc_pkg.sv
// Shared definitions for the ADC128S-style SPI converter model.
//   - channel numbers of the populated inputs
//   - SPI frame geometry and the position of the channel field in the command
//   - rising-edge counter type and the helper that builds the TX word
package adc_pkg;

  localparam int FRAME_BITS   = 16;
  localparam int DATA_BITS    = 12;
  localparam int CMD_CHAN_MSB = 13;
  localparam int CMD_CHAN_LSB = 11;
  localparam int CNT_BITS     = 5;

  typedef logic [2:0]            chan_t;
  typedef logic [CNT_BITS-1:0]   cnt_t;
  typedef logic [DATA_BITS-1:0]  sample_t;
  typedef logic [FRAME_BITS-1:0] word_t;

  localparam chan_t CH_LD_LFT  = 3'd0;
  localparam chan_t CH_LD_RGHT = 3'd4;
  localparam chan_t CH_STEER   = 3'd5;
  localparam chan_t CH_BATT    = 3'd6;

  localparam cnt_t CNT_MAX  = '1;
  localparam cnt_t CNT_FULL = cnt_t'(FRAME_BITS);

  // Result word: four leading zeros, then the 12-bit sample, MSB first.
  function automatic word_t tx_word(input sample_t value);
    return {{(FRAME_BITS-DATA_BITS){1'b0}}, value};
  endfunction

endpackage

// File: rtl/adc128s_fc_if.sv
// SPI bus between the A2D master (DUT under test) and the converter model.
//   SS_n : active-low chip select, master -> slave
//   SCLK : serial clock, idles high, master -> slave
//   MOSI : command bits, MSB first, master -> slave
//   MISO : result bits, MSB first, slave -> master
interface adc128s_fc_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc_spi_edge.sv
// Brings the asynchronous SPI pins into the clk domain and detects edges.
//   clk, rst_n            : system clock, async active-low reset
//   ss_n_raw/sclk_raw     : SPI pins straight from the bus
//   mosi_raw              : command data pin
//   ss_active             : synchronised chip select is asserted (low)
//   ss_fall/ss_rise       : one-clk pulses on chip-select edges
//   sclk_rise/sclk_fall   : one-clk pulses on SCLK edges
//   mosi                  : MOSI delayed by the same two flops as SCLK, so it
//                           lines up with sclk_rise
module adc_spi_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ss_n_raw,
  input  logic sclk_raw,
  input  logic mosi_raw,
  output logic ss_active,
  output logic ss_fall,
  output logic ss_rise,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi
);

  // [0],[1] form the synchroniser, [2] holds the previous synced value.
  logic [2:0] ss_sync;
  logic [2:0] sclk_sync;
  logic [1:0] mosi_sync;

  // Idle-high reset values keep a bus at rest from looking like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its neighbour, which is what turns these vectors into shift chains.
      ss_sync   <= {ss_sync[1:0], ss_n_raw};
      sclk_sync <= {sclk_sync[1:0], sclk_raw};
      mosi_sync <= {mosi_sync[0], mosi_raw};
    end
  end

  assign ss_active = ~ss_sync[1];
  assign ss_fall   =  ss_sync[2] & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2] &  ss_sync[1];
  assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
  assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
  assign mosi      =  mosi_sync[1];

endmodule

// File: rtl/adc128s_fc.sv
// Behavioural-but-synthesizable 8-channel 12-bit SPI A2D converter model.
// Each frame carries a channel command; the result for that channel comes
// back in the following frame.
//   clk, rst_n   : system clock, async active-low reset
//   spi          : SPI slave port (SS_n, SCLK, MOSI in; MISO out)
//   ld_cell_lft  : value for channel 0
//   ld_cell_rght : value for channel 4
//   steerPot     : value for channel 5
//   batt         : value for channel 6
//   Channels 1, 2, 3 and 7 read as zero.
module adc128s_fc
  import adc_pkg::*;
#(
  parameter int SCLK_MIN_PHASE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  adc128s_fc_if.slave      spi,
  input  logic [11:0]      ld_cell_lft,
  input  logic [11:0]      ld_cell_rght,
  input  logic [11:0]      steerPot,
  input  logic [11:0]      batt
);

  // Edge detection takes two clocks and the TX update one more, so shorter
  // SCLK phases would let the master sample MISO before it has moved.
  if (SCLK_MIN_PHASE < 3) begin : g_phase_chk
    $error("adc128s_fc: SCLK_MIN_PHASE must be at least 3");
  end

  logic    ss_active, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi;
  word_t   tx;
  word_t   rx;
  cnt_t    rise_cnt;
  chan_t   chan_ptr;
  sample_t chan_value;

  adc_spi_edge u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n_raw  (spi.SS_n),
    .sclk_raw  (spi.SCLK),
    .mosi_raw  (spi.MOSI),
    .ss_active (ss_active),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi      (mosi)
  );

  always_comb begin
    // NOTE: the default before the case keeps this purely combinational; a
    // path that left chan_value unassigned would infer a latch.
    chan_value = '0;
    case (chan_ptr)
      CH_LD_LFT:  chan_value = ld_cell_lft;
      CH_LD_RGHT: chan_value = ld_cell_rght;
      CH_STEER:   chan_value = steerPot;
      CH_BATT:    chan_value = batt;
      default:    chan_value = '0;
    endcase
  end

  // The value is captured once at frame start, so input changes mid-frame
  // never disturb the bits already on their way out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= '0;
      rx       <= '0;
      rise_cnt <= '0;
    end else if (ss_fall) begin
      tx       <= tx_word(chan_value);
      rise_cnt <= '0;
    end else if (ss_active) begin
      if (sclk_rise) begin
        rx <= {rx[FRAME_BITS-2:0], mosi};
        if (rise_cnt != CNT_MAX) rise_cnt <= rise_cnt + cnt_t'(1);
      end
      // SCLK idles high, so the first fall of a frame precedes any rise and
      // has no bit to advance past; a zero rise count identifies it.
      if (sclk_fall && rise_cnt != '0) tx <= {tx[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Only a complete frame may retarget the pipeline; short frames are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_ptr <= CH_LD_LFT;
    end else if (ss_rise && rise_cnt == CNT_FULL) begin
      chan_ptr <= rx[CMD_CHAN_MSB:CMD_CHAN_LSB];
    end
  end

  // Gated by the raw pin so MISO drops the moment chip select is released.
  assign spi.MISO = ~spi.SS_n & tx[FRAME_BITS-1];

  // Only the channel field of the command is meaningful.
  logic unused_rx_bits;
  assign unused_rx_bits = ^{rx[FRAME_BITS-1:CMD_CHAN_MSB+1], rx[CMD_CHAN_LSB-1:0]};

endmodule

// File: tb/tb_adc128s_fc.sv
// Self-checking bench for adc128s_fc. The stimulus process runs SPI frames
// and queues the word each checked frame must return; an independent monitor
// assembles MISO bits at SCLK rises and compares at the end of each frame.
module tb_adc128s_fc;

  localparam int PH = 5;  // SCLK half period in clk cycles

  logic        clk;
  logic        rst_n;
  logic [11:0] ld_cell_lft, ld_cell_rght, steer_pot, batt;

  adc128s_fc_if spi ();

  adc128s_fc #(.SCLK_MIN_PHASE(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi          (spi.slave),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steer_pot),
    .batt         (batt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] sb_q[$];
  bit          expect_frame = 1'b0;
  int          frame_no = 0;
  int          mon_cnt = 0;
  logic [15:0] mon_word = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: collect the bits the master would sample.
  always @(negedge spi.SS_n) begin
    mon_cnt  = 0;
    mon_word = '0;
  end

  always @(posedge spi.SCLK) begin
    if (spi.SS_n === 1'b0) begin
      mon_word = {mon_word[14:0], spi.MISO};
      mon_cnt++;
    end
  end

  always @(posedge spi.SS_n) begin
    if (expect_frame) begin
      frame_no++;
      if (mon_cnt != 16 || sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame%0d_shape: got %0d bits, %0d queued, expected 16 bits and an entry",
                 frame_no, mon_cnt, sb_q.size());
      end else begin
        check($sformatf("frame%0d_word", frame_no), mon_word, sb_q.pop_front());
      end
    end
  end

  // action: 0 none, 1 steerPot -> FFF mid-frame, 2 reset pulse mid-frame
  task automatic frame(input logic [2:0] ch, input int nbits, input bit chk,
                       input logic [15:0] exp, input int action);
    logic [15:0] cmd;
    cmd = {2'b10, ch, 11'h2AA};  // don't-care fields deliberately non-zero
    expect_frame = chk;
    if (chk) sb_q.push_back(exp);
    @(negedge clk);
    spi.SS_n = 1'b0;
    repeat (PH) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.SCLK = 1'b0;
      spi.MOSI = cmd[15-i];
      repeat (PH) @(negedge clk);
      spi.SCLK = 1'b1;
      repeat (PH) @(negedge clk);
      if (i == 7 && action == 1) steer_pot = 12'hFFF;
      if (i == 7 && action == 2) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("miso_in_reset", {15'b0, spi.MISO}, 16'h0000);
        rst_n = 1'b1;
      end
    end
    spi.SS_n = 1'b1;
    repeat (2) @(negedge clk);
    check("miso_idle", {15'b0, spi.MISO}, 16'h0000);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    spi.SS_n     = 1'b1;
    spi.SCLK     = 1'b1;
    spi.MOSI     = 1'b0;
    ld_cell_lft  = 12'h400;
    ld_cell_rght = 12'h400;
    steer_pot    = 12'h7FF;
    batt         = 12'hFFF;
    repeat (3) @(negedge clk);
    check("reset_miso", {15'b0, spi.MISO}, 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    //     cmd   bits chk expected  action   (pointer before frame)
    frame(3'd0, 16, 1, 16'h0400, 0);  // ptr 0 after reset
    frame(3'd0, 16, 1, 16'h0400, 0);  // ptr 0
    frame(3'd6, 16, 1, 16'h0400, 0);  // ptr 0, still previous channel
    frame(3'd4, 16, 1, 16'h0FFF, 0);  // ptr 6 -> batt
    frame(3'd5, 16, 1, 16'h0400, 0);  // ptr 4 -> ld_cell_rght
    frame(3'd4, 16, 1, 16'h07FF, 0);  // ptr 5 -> steerPot
    frame(3'd6, 16, 1, 16'h0400, 0);  // ptr 4
    frame(3'd5,  8, 0, 16'h0000, 0);  // short frame, ptr stays 6
    frame(3'd3, 16, 1, 16'h0FFF, 0);  // ptr 6 -> batt
    frame(3'd5, 16, 1, 16'h0000, 0);  // ptr 3 -> unpopulated
    steer_pot = 12'h000;
    frame(3'd5, 16, 1, 16'h0000, 1);  // ptr 5, steerPot captured as 000
    frame(3'd1, 16, 1, 16'h0FFF, 0);  // ptr 5, new steerPot
    frame(3'd6, 16, 0, 16'h0000, 2);  // aborted by reset, ptr back to 0
    frame(3'd7, 16, 1, 16'h0400, 0);  // ptr 0 -> ld_cell_lft
    frame(3'd2, 16, 1, 16'h0000, 0);  // ptr 7 -> zero
    frame(3'd0, 16, 1, 16'h0000, 0);  // ptr 2 -> zero

    check("sb_drained", 16'(sb_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc128s_fc.md
# adc128s_fc

Behavioural-but-synthesizable model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style) used in the Segway system bench. It serves the DUT's A2D interface with left/right load-cell, steering-pot and battery readings supplied as bench inputs. Each SPI frame selects a channel, and the conversion result for that channel is returned in the following frame.

## Interface
- `SCLK_MIN_PHASE`, default 4: minimum SCLK high or low time in `clk` cycles that the model must tolerate.
- `clk` input 1: system clock; every SPI pin is sampled on it.
- `rst_n` input 1: reset, asynchronous active-low (one clock; reset is asynchronous and active-low).
- `SS_n` input 1: active-low chip select; one frame per low period.
- `SCLK` input 1: SPI clock, idles high.
- `MOSI` input 1: command bits from the master, MSB first.
- `MISO` output 1: result bits to the master, MSB first.
- `ld_cell_lft` input 12: value returned for channel 0.
- `ld_cell_rght` input 12: value returned for channel 4.
- `steerPot` input 12: value returned for channel 5.
- `batt` input 12: value returned for channel 6.

## Operation
- Frame length is 16 SCLK periods. The command word is `{2'bxx, chan[2:0], 11'bx}`, so the channel is taken from bits [13:11].
- Pipelined protocol: the data returned in frame N is for the channel commanded in frame N-1. After reset the channel pointer is 0.
- Channel map: 0→`ld_cell_lft`, 4→`ld_cell_rght`, 5→`steerPot`, 6→`batt`. Channels 1, 2, 3 and 7 return 12'h000.
- On the `SS_n` falling edge, load the 16-bit TX shift register with `{4'h0, value[chan_ptr]}`. The value is sampled at that instant and stays stable for the whole frame.
- On each SCLK rising edge, shift `MOSI` into the 16-bit RX register.
- On each SCLK falling edge, shift TX left by one. The first falling edge after `SS_n` fall is ignored, because no leading edge occurs with SCLK idling high.
- `MISO` equals TX[15] while `SS_n` is low, and 0 while `SS_n` is high.
- On the `SS_n` rising edge:
  - If exactly 16 rising edges were counted, `chan_ptr` takes RX[13:11].
  - Otherwise the frame is discarded and `chan_ptr` is unchanged.
- Edges are detected by a two-flop synchroniser plus a previous-value flop on `SCLK` and `SS_n`. `MOSI` is taken from a matching two-flop synchroniser.
- A 5-bit rising-edge counter is cleared on the `SS_n` fall and saturates at 31.

## Timing
- Reset values: `MISO`=0, `chan_ptr`=0, TX=0, RX=0, counter=0, all synchroniser flops = 1 (SS_n/SCLK idle high).
- `MISO` is valid with the first data bit no later than 4 `clk` cycles after the `SS_n` fall.
- Each later bit is valid no later than 4 `clk` cycles after the SCLK fall.
- The master samples `MISO` on the SCLK rise. SCLK phases must be ≥ `SCLK_MIN_PHASE` clocks.
- `chan_ptr` updates 3 clocks after the `SS_n` rise. The next `SS_n` fall must come at least 4 clocks later.
- `SS_n` falling mid-reset has no effect. Reset asserted mid-frame aborts the frame immediately: all state returns to reset values.
- A new `SS_n` fall while the previous frame is incomplete is impossible, since it needs a rise first. A short frame leaves the pointer intact.
- Bench input changes during a frame do not affect that frame's `MISO` data.

## Structure
- Shared package `adc_pkg` holds:
  - channel constants `CH_LD_LFT=3'd0`, `CH_LD_RGHT=3'd4`, `CH_STEER=3'd5`, `CH_BATT=3'd6`;
  - `FRAME_BITS=16`;
  - the command-field bit positions.
- One sub-module, `adc_spi_edge`: synchroniser and edge detector producing `ss_fall`, `ss_rise`, `sclk_rise`, `sclk_fall` and synced `mosi`.
- The top level holds the shift registers, counter, channel pointer and output mux.

## Test plan
- Reset, then frame 1 with command chan=0, then frame 2 with chan=0, with `ld_cell_lft`=12'h400 → frame 2 `MISO` word = 16'h0400.
- Frame commanding chan=6 with `batt`=12'hFFF, then any frame → returned word 16'h0FFF. The frame before it returns the previous channel's data.
- Sequence of commands chan 4, 5, 4 with `ld_cell_rght`=12'h400 and `steerPot`=12'h7FF → frames 2, 3 and 4 return 16'h0400, 16'h07FF and 16'h0400 respectively.
- Short frame of 8 SCLKs carrying chan=5 after a valid chan=6 frame → next frame still returns `batt`.
- Command chan=3 → next frame returns 16'h0000. `MISO` is 0 whenever `SS_n` is high.
- Change `steerPot` from 12'h000 to 12'hFFF midway through a chan-5 data frame → that frame returns 16'h0000 and the following frame returns 16'h0FFF. Also assert `rst_n` mid-frame → `MISO`=0 and the pointer is 0 on recovery.
